// File: rtl/dff_pkg.sv
// Shared defaults and width helpers for the valid/ready register pipeline.
package dff_pkg;

    localparam int DFF_WIDTH = 8;
    localparam int DFF_DEPTH = 4;

    // Bits needed to count 0..depth valid stages.
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// Valid/ready stream bundle between an upstream driver, the pipeline and a downstream sink.
interface dff_pipe_if
    import dff_pkg::*;
#(
    parameter int WIDTH = DFF_WIDTH,
    parameter int DEPTH = DFF_DEPTH
) (
    input logic clk
);

    localparam int CW = cnt_w(DEPTH);

    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic [CW-1:0]    count;

    modport master (
        input  clk,
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, count
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, count
    );

    // Edge-aligned views of the handshake for driver and monitor code.
    clocking drv_cb @(posedge clk);
        input in_ready, out_valid;
    endclocking

    clocking mon_cb @(posedge clk);
        input in_valid, in_ready, out_valid, out_ready, flush, count;
    endclocking

endinterface

// File: rtl/dff_pipe_stage.sv
// One pipeline slot: data and valid register with load enable, clear and async reset.
module dff_pipe_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    input  logic             v_in,
    output logic [WIDTH-1:0] q,
    output logic             v
);

    // Clear drops only the valid bit; the data word keeps its last value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= RESET_VAL;
            v <= 1'b0;
        end else begin
            if (clear) begin
                v <= 1'b0;
            end else if (load) begin
                v <= v_in;
            end
            if (load && !clear) begin
                q <= d;
            end
        end
    end

endmodule

// File: rtl/dff_pipe.sv
// Elastic register pipeline: DEPTH valid/ready stages with bubble collapse, flush and occupancy count.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_WIDTH,
    parameter int               DEPTH     = DFF_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic     clk,
    input  logic     rst,
    dff_pipe_if.slave bus
);

    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [WIDTH-1:0] up_data    [DEPTH];
    logic [DEPTH-1:0] stage_vld;
    logic [DEPTH-1:0] up_vld;
    logic [DEPTH-1:0] ready;
    logic [DEPTH-1:0] load;
    logic             rdy_acc;
    logic             in_fire;
    logic             out_fire;
    logic [CW-1:0]    count_q;

    // A stage can take new data if it is empty or anything downstream of it is.
    always_comb begin
        ready   = '0;
        rdy_acc = bus.out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            rdy_acc  = rdy_acc | ~stage_vld[i];
            ready[i] = rdy_acc;
        end
    end

    assign load         = ready & {DEPTH{~bus.flush}};
    assign bus.in_ready = ready[0] & ~bus.flush & ~rst;

    assign up_data[0] = bus.in_data;
    assign up_vld[0]  = bus.in_valid;

    genvar g;
    generate
        for (g = 0; g < DEPTH; g++) begin : g_stage
            if (g > 0) begin : g_link
                assign up_data[g] = stage_data[g-1];
                assign up_vld[g]  = stage_vld[g-1];
            end

            dff_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk   (clk),
                .rst   (rst),
                .load  (load[g]),
                .clear (bus.flush),
                .d     (up_data[g]),
                .v_in  (up_vld[g]),
                .q     (stage_data[g]),
                .v     (stage_vld[g])
            );
        end
    endgenerate

    assign bus.out_valid = stage_vld[DEPTH-1];
    assign bus.out_data  = stage_data[DEPTH-1];

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = bus.out_valid & bus.out_ready;

    // Occupancy tracks transfers, so it always equals the number of valid stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (bus.flush) begin
            count_q <= '0;
        end else if (in_fire && !out_fire) begin
            count_q <= count_q + CW'(1);
        end else if (!in_fire && out_fire) begin
            count_q <= count_q - CW'(1);
        end
    end

    assign bus.count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Bench for dff_pipe: vector table plus directed streaming, backpressure, flush and reset sequences.
module tb_dff_pipe;
    import dff_pkg::*;

    localparam int         WIDTH   = 8;
    localparam int         DEPTH   = 4;
    localparam logic [7:0] RST_VAL = 8'hC3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus (.clk(clk));

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (RST_VAL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        logic [7:0] e_od;
        int         e_cnt;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_err    = 0;
    logic       ir, ov;
    logic [7:0] od;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                       input logic e_ir, input logic e_ov, input logic [7:0] e_od, input int e_cnt);
        vec_t v;
        v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
        v.e_ir = e_ir; v.e_ov = e_ov; v.e_od = e_od; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    // Entered 1 time unit after a rising edge; returns 1 unit after the next one.
    task automatic cycle(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                         output logic ir_s, output logic ov_s, output logic [7:0] od_s);
        logic       exp_ir;
        logic [7:0] e;
        bus.in_valid  = iv;
        bus.in_data   = id;
        bus.out_ready = ordy;
        bus.flush     = fl;
        #3;
        ir_s   = bus.in_ready;
        ov_s   = bus.out_valid;
        od_s   = bus.out_data;
        exp_ir = ((exp_q.size() < DEPTH) || ordy) && !fl;
        chk("in_ready", ir_s, exp_ir);
        if (exp_q.size() == 0) chk("out_valid_empty", ov_s, 0);
        if (ov_s && ordy) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_out: got 0x%0h, want no output", od_s);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", od_s, e);
            end
        end
        if (iv && exp_ir) exp_q.push_back(id);
        if (fl) exp_q.delete();
        @(posedge clk);
        #1;
        chk("count", bus.count, exp_q.size());
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        bus.flush     = 1'b0;

        #1 rst = 1'b1;
        #1;
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_count", bus.count, 0);
        chk("reset_in_ready", bus.in_ready, 0);
        chk("reset_out_data", bus.out_data, RST_VAL);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Continuous stream with the sink always ready.
        for (int k = 0; k < 8; k++) begin
            cycle(1'b1, 8'(k + 1), 1'b1, 1'b0, ir, ov, od);
            chk("stream_out_valid", bus.out_valid, (k >= 3) ? 1 : 0);
            if (k >= 3) chk("stream_count_full", bus.count, 4);
            if (k >= 4) chk("full_in_ready", ir, 1);
        end
        for (int k = 0; k < 4; k++) cycle(1'b0, 8'h00, 1'b1, 1'b0, ir, ov, od);

        // Backpressure fill and release.
        add(1, 8'hA0, 0, 0, 1, 0, 8'h00, 1);
        add(1, 8'hA1, 0, 0, 1, 0, 8'h00, 2);
        add(1, 8'hA2, 0, 0, 1, 0, 8'h00, 3);
        add(1, 8'hA3, 0, 0, 1, 0, 8'h00, 4);
        add(1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4);
        add(1, 8'hA4, 0, 0, 0, 1, 8'hA0, 4);
        add(1, 8'hA4, 1, 0, 1, 1, 8'hA0, 4);
        add(1, 8'hA5, 1, 0, 1, 1, 8'hA1, 4);
        add(0, 8'h00, 1, 0, 1, 1, 8'hA2, 3);
        add(0, 8'h00, 1, 0, 1, 1, 8'hA3, 2);
        add(0, 8'h00, 1, 0, 1, 1, 8'hA4, 1);
        add(0, 8'h00, 1, 0, 1, 1, 8'hA5, 0);
        // Flush at count 3 with a competing input.
        add(1, 8'hB0, 0, 0, 1, 0, 8'h00, 1);
        add(1, 8'hB1, 0, 0, 1, 0, 8'h00, 2);
        add(1, 8'hB2, 0, 0, 1, 0, 8'h00, 3);
        add(1, 8'hB3, 0, 1, 0, 0, 8'h00, 0);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);
        // Single item walking to the output under backpressure.
        add(1, 8'h3C, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 1);
        add(0, 8'h00, 0, 0, 1, 1, 8'h3C, 1);
        add(0, 8'h00, 1, 0, 1, 1, 8'h3C, 0);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].iv, vecs[i].id, vecs[i].ordy, vecs[i].fl, ir, ov, od);
            chk($sformatf("vec%0d_in_ready", i), ir, vecs[i].e_ir);
            chk($sformatf("vec%0d_out_valid", i), ov, vecs[i].e_ov);
            if (vecs[i].e_ov) chk($sformatf("vec%0d_out_data", i), od, vecs[i].e_od);
            chk($sformatf("vec%0d_count", i), bus.count, vecs[i].e_cnt);
        end

        // Asynchronous reset between edges while data is in flight.
        cycle(1'b1, 8'h11, 1'b1, 1'b0, ir, ov, od);
        cycle(1'b1, 8'h12, 1'b1, 1'b0, ir, ov, od);
        cycle(1'b1, 8'h13, 1'b1, 1'b0, ir, ov, od);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_count", bus.count, 0);
        chk("midrst_out_data", bus.out_data, RST_VAL);
        chk("midrst_in_ready", bus.in_ready, 0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        cycle(1'b1, 8'h55, 1'b1, 1'b0, ir, ov, od);
        chk("post_rst_accept", ir, 1);
        for (int k = 0; k < 3; k++) begin
            chk("post_rst_latency", bus.out_valid, 0);
            cycle(1'b0, 8'h00, 1'b1, 1'b0, ir, ov, od);
        end
        chk("post_rst_out_valid", bus.out_valid, 1);
        chk("post_rst_out_data", bus.out_data, 8'h55);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, ir, ov, od);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dff_pipe.md
DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001 Parameter WIDTH, default 8, data bits per stage (>=1) SHALL be supported.
REQ-002 Parameter DEPTH, default 4, number of register stages (>=1) SHALL be supported.
REQ-003 Parameter RESET_VAL, default 0, WIDTH-bit data value loaded on reset SHALL be supported.
REQ-004 clk  input  1  single clock SHALL be provided; all state changes on its rising edge.
REQ-005 rst  input  1  reset SHALL be asynchronous and active-high.
REQ-006 flush  input  1  synchronous pipeline clear SHALL be provided.
REQ-007 in_valid  input  1  upstream data-valid SHALL be provided.
REQ-008 in_data  input  WIDTH  upstream data SHALL be provided.
REQ-009 in_ready  output  1  accept indication to upstream SHALL be provided.
REQ-010 out_valid  output  1  stage DEPTH-1 valid SHALL be provided.
REQ-011 out_data  output  WIDTH  stage DEPTH-1 data SHALL be provided.
REQ-012 out_ready  input  1  downstream accept SHALL be provided.
REQ-013 count  output  $clog2(DEPTH+1)  number of valid stages SHALL be provided.

Function
REQ-014 Stages SHALL be indexed 0 (input side) to DEPTH-1 (output side), each holding data and a valid bit.
REQ-015 Stage i ready SHALL equal !valid[i] || ready[i+1], with ready[DEPTH] = out_ready (combinational chain).
REQ-016 in_ready SHALL equal ready[0] && !flush.
REQ-017 Input transfer SHALL occur on an edge where in_valid && in_ready; output transfer where out_valid && out_ready.
REQ-018 Stage i SHALL load stage i-1 (or input for i=0) when ready[i] is high, taking the upstream valid bit.
REQ-019 Latency SHALL be DEPTH edges from input transfer to out_valid on an empty, unstalled pipe.
REQ-020 Throughput SHALL be one transfer per cycle when out_ready stays high, including when full.
REQ-021 Bubbles SHALL collapse: under backpressure, valid data advances into empty downstream stages.
REQ-022 While out_valid && !out_ready, out_valid and out_data SHALL hold stable.
REQ-023 Ordering SHALL be preserved; no item dropped or duplicated absent flush/reset.
REQ-024 count SHALL update each edge: +1 on input-only, -1 on output-only, unchanged on both or neither.
REQ-025 Full (count==DEPTH, out_ready=0) SHALL force in_ready=0; empty (count==0) SHALL force out_valid=0.
REQ-026 flush SHALL clear all valid bits and count to 0 at the next edge, overriding simultaneous input transfer; data registers unchanged.
REQ-027 An output transfer in the flush cycle SHALL count as delivered.
REQ-028 out_data SHALL be stage DEPTH-1 data regardless of valid.

Reset
REQ-029 Asserting rst SHALL immediately, without a clock edge, clear all valid bits, load RESET_VAL into all stages, and zero count.
REQ-030 While rst is high, out_valid=0, count=0, in_ready=0.
REQ-031 Reset mid-operation SHALL discard in-flight data; first transfer allowed on the first edge after deassertion.

Structure
REQ-032 Package dff_pkg SHALL hold default WIDTH/DEPTH constants and a count-width helper function.
REQ-033 One sub-module dff_pipe_stage (data+valid register with load enable, async reset, clear) SHALL be instantiated DEPTH times via generate.
REQ-034 The existing driver/monitor interface SHALL be extended with clocking blocks for the valid/ready/flush signals.

Verification (WIDTH=8, DEPTH=4)
REQ-035 Stream 0x01..0x08, out_ready=1 -> out_valid rises 4 edges after first accept, values 0x01..0x08 in order, count steady at 4.
REQ-036 out_ready=0, send 0xA0..0xA5 -> exactly 0xA0..0xA3 accepted, in_ready=0 after 4th, count=4, out_data held 0xA0; release -> 0xA0..0xA5 in order.
REQ-037 Full pipe, out_ready=1, in_valid=1 -> in_ready=1, one in and one out per edge, count stays 4.
REQ-038 count=3, flush=1 with in_valid=1 -> next edge count=0, out_valid=0, input not accepted, in_ready=1 after flush drops.
REQ-039 rst asserted mid-stream between edges -> out_valid=0, count=0, out_data=RESET_VAL before next edge; post-release 0x55 emerges after 4 edges.
REQ-040 Single item 0x3C with out_ready=0 -> reaches output stage after 4 edges, count=1, held until out_ready=1.
